branch_update_queue: RTL and testbench

In-order queue of in-flight conditional branches between fetch and the gshare branch predictor's update port. Fetch allocates one entry per predicted branch, recording the PC and the predicted direction. Execute resolves entries by tag, in any order. The queue retires resolved entries strictly in program order and drives the predictor's update_valid / update_pc / actual_branch_taken inputs, one branch per cycle, so the predictor's BHR is trained in program order.

---
 rtl/branch_update_queue.sv | 113 +++++++++++
 tb/tb_branch_update_queue.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_update_queue.sv
// rtl/branch_update_queue.sv - in-order retire queue feeding gshare predictor updates
// Entries allocate at tail, resolve by tag out of order, and drain from head one per cycle.
module branch_update_queue #(
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    input  logic [31:0]      alloc_pc,
    input  logic             alloc_pred,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             resolve_valid,
    input  logic [TAG_W-1:0] resolve_tag,
    input  logic             resolve_taken,
    input  logic             flush,
    output logic             update_valid,
    output logic [31:0]      update_pc,
    output logic             actual_branch_taken,
    output logic             update_mispredict,
    output logic [TAG_W:0]   count
);
    localparam int PTR_W = TAG_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] resolved_q;
    logic [DEPTH-1:0] pred_q;
    logic [DEPTH-1:0] taken_q;
    logic [31:0]      pc_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;

    logic             update_valid_q;
    logic [31:0]      update_pc_q;
    logic             update_taken_q;
    logic             update_mispredict_q;

    logic [TAG_W-1:0] head_idx;
    logic [TAG_W-1:0] tail_idx;
    logic             full;
    logic             do_alloc;
    logic             do_resolve;
    logic             do_drain;

    assign head_idx = head_q[TAG_W-1:0];
    assign tail_idx = tail_q[TAG_W-1:0];
    // Full: same index, opposite wrap bits.
    assign full     = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);

    assign alloc_ready = !full;
    assign alloc_tag   = tail_idx;
    assign count       = tail_q - head_q;

    always_comb begin
        do_alloc   = alloc_valid && !full;
        do_resolve = resolve_valid && valid_q[resolve_tag] && !resolved_q[resolve_tag];
        do_drain   = valid_q[head_idx] && resolved_q[head_idx];
        head_d     = head_q;
        tail_d     = tail_q;
        if (do_drain) begin
            head_d = head_q + PTR_ONE;
        end
        if (do_alloc) begin
            tail_d = tail_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q             <= '0;
            head_q              <= '0;
            tail_q              <= '0;
            update_valid_q      <= 1'b0;
            update_pc_q         <= '0;
            update_taken_q      <= 1'b0;
            update_mispredict_q <= 1'b0;
        end else if (flush) begin
            valid_q        <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            update_valid_q <= 1'b0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            update_valid_q <= do_drain;
            if (do_drain) begin
                update_pc_q         <= pc_q[head_idx];
                update_taken_q      <= taken_q[head_idx];
                update_mispredict_q <= pred_q[head_idx] ^ taken_q[head_idx];
                valid_q[head_idx]   <= 1'b0;
            end
            // Resolve only sees pre-edge valid bits, so a same-cycle alloc of that tag is missed.
            if (do_resolve) begin
                resolved_q[resolve_tag] <= 1'b1;
                taken_q[resolve_tag]    <= resolve_taken;
            end
            if (do_alloc) begin
                valid_q[tail_idx]    <= 1'b1;
                resolved_q[tail_idx] <= 1'b0;
                pred_q[tail_idx]     <= alloc_pred;
                pc_q[tail_idx]       <= alloc_pc;
            end
        end
    end

    assign update_valid        = update_valid_q;
    assign update_pc           = update_pc_q;
    assign actual_branch_taken = update_taken_q;
    assign update_mispredict   = update_mispredict_q;
endmodule

// File: tb/tb_branch_update_queue.sv
// tb/tb_branch_update_queue.sv - directed bench with a queue-based program-order model
module tb_branch_update_queue;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_valid;
    logic [31:0] alloc_pc;
    logic        alloc_pred;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        resolve_valid;
    logic [2:0]  resolve_tag;
    logic        resolve_taken;
    logic        flush;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        actual_branch_taken;
    logic        update_mispredict;
    logic [3:0]  count;

    int tests  = 0;
    int errors = 0;

    branch_update_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .resolve_taken(resolve_taken),
        .flush(flush),
        .update_valid(update_valid), .update_pc(update_pc),
        .actual_branch_taken(actual_branch_taken), .update_mispredict(update_mispredict),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  tag;
        logic [31:0] pc;
        logic        pred;
        logic        res;
        logic        tk;
    } ent_t;

    ent_t        mq[$];
    int          mtail = 0;
    logic        e_uv = 1'b0;
    logic [31:0] e_pc = '0;
    logic        e_tk = 1'b0;
    logic        e_mp = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Program-order model: a list of in-flight branches, oldest first.
    always @(posedge clk) begin
        int n;
        n = mq.size();
        if (rst) begin
            mq.delete();
            mtail = 0;
            e_uv = 1'b0; e_pc = '0; e_tk = 1'b0; e_mp = 1'b0;
        end else if (flush) begin
            mq.delete();
            mtail = 0;
            e_uv = 1'b0;
        end else begin
            e_uv = 1'b0;
            if (n > 0 && mq[0].res) begin
                e_uv = 1'b1;
                e_pc = mq[0].pc;
                e_tk = mq[0].tk;
                e_mp = mq[0].pred ^ mq[0].tk;
                void'(mq.pop_front());
            end
            if (resolve_valid) begin
                foreach (mq[i]) begin
                    if (mq[i].tag == resolve_tag && !mq[i].res) begin
                        mq[i].res = 1'b1;
                        mq[i].tk  = resolve_taken;
                    end
                end
            end
            if (alloc_valid && n < DEPTH) begin
                mq.push_back('{tag: 3'(mtail % DEPTH), pc: alloc_pc, pred: alloc_pred, res: 1'b0, tk: 1'b0});
                mtail++;
            end
        end
    end

    always @(negedge clk) begin
        chk("count", 32'(count), 32'(mq.size()));
        chk("alloc_ready", 32'(alloc_ready), 32'(mq.size() < DEPTH));
        chk("alloc_tag", 32'(alloc_tag), 32'(mtail % DEPTH));
        chk("update_valid", 32'(update_valid), 32'(e_uv));
        chk("update_pc", update_pc, e_pc);
        chk("actual_branch_taken", 32'(actual_branch_taken), 32'(e_tk));
        chk("update_mispredict", 32'(update_mispredict), 32'(e_mp));
    end

    task automatic step(input logic av, input logic [31:0] pc, input logic pr,
                        input logic rv, input logic [2:0] rt, input logic rk,
                        input logic fl, input logic r);
        alloc_valid = av; alloc_pc = pc; alloc_pred = pr;
        resolve_valid = rv; resolve_tag = rt; resolve_taken = rk;
        flush = fl; rst = r;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic alloc(input logic [31:0] pc, input logic pr);
        step(1'b1, pc, pr, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic res(input logic [2:0] t, input logic k);
        step(1'b0, 32'h0, 1'b0, 1'b1, t, k, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        alloc_valid = 1'b0; alloc_pc = '0; alloc_pred = 1'b0;
        resolve_valid = 1'b0; resolve_tag = '0; resolve_taken = 1'b0;
        flush = 1'b0; rst = 1'b1;
        @(negedge clk);
        do_reset();
        chk("reset alloc_ready", 32'(alloc_ready), 32'd1);
        chk("reset count", 32'(count), 32'd0);
        chk("reset update_pc", update_pc, 32'd0);

        // Minimum latency with a mispredict.
        alloc(32'h100, 1'b1);
        res(3'd0, 1'b0);
        chk("lat no early pulse", 32'(update_valid), 32'd0);
        idle();
        chk("lat update_valid", 32'(update_valid), 32'd1);
        chk("lat update_pc", update_pc, 32'h100);
        chk("lat mispredict", 32'(update_mispredict), 32'd1);
        idle();
        chk("lat single pulse", 32'(update_valid), 32'd0);

        // Out-of-order resolve, in-order retire.
        do_reset();
        alloc(32'h10, 1'b0); alloc(32'h20, 1'b0); alloc(32'h30, 1'b0);
        res(3'd2, 1'b1);
        res(3'd0, 1'b1);
        chk("ooo wait head", 32'(update_valid), 32'd0);
        res(3'd1, 1'b0);
        chk("ooo first pc", update_pc, 32'h10);
        idle();
        chk("ooo second pc", update_pc, 32'h20);
        idle();
        chk("ooo third pc", update_pc, 32'h30);
        chk("ooo third taken", 32'(actual_branch_taken), 32'd1);
        idle();

        // Fill, reject, drain, wrap.
        do_reset();
        for (int i = 0; i < DEPTH; i++) alloc(32'h200 + 32'(i * 4), 1'(i));
        chk("full ready", 32'(alloc_ready), 32'd0);
        chk("full count", 32'(count), 32'd8);
        alloc(32'hDEAD, 1'b1);
        chk("full dropped", 32'(count), 32'd8);
        res(3'd0, 1'b1);
        chk("full still not ready", 32'(alloc_ready), 32'd0);
        alloc(32'hBEEF, 1'b0);
        chk("full rejected while draining", 32'(count), 32'd7);
        chk("wrap alloc_tag", 32'(alloc_tag), 32'd0);
        alloc(32'h300, 1'b0);
        chk("wrap count", 32'(count), 32'd8);
        idle();

        // Double and stray resolves are ignored.
        do_reset();
        alloc(32'h40, 1'b0); alloc(32'h44, 1'b1);
        res(3'd1, 1'b1);
        res(3'd1, 1'b0);
        res(3'd5, 1'b0);
        res(3'd0, 1'b0);
        idle();
        chk("dbl first pc", update_pc, 32'h40);
        idle();
        chk("dbl second taken", 32'(actual_branch_taken), 32'd1);
        chk("dbl second mispredict", 32'(update_mispredict), 32'd0);
        idle();

        // Flush beats alloc and resolve.
        do_reset();
        for (int i = 0; i < 5; i++) alloc(32'h500 + 32'(i), 1'b0);
        res(3'd1, 1'b1); res(3'd2, 1'b1); res(3'd3, 1'b1);
        step(1'b1, 32'h600, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
        chk("flush count", 32'(count), 32'd0);
        chk("flush alloc_tag", 32'(alloc_tag), 32'd0);
        chk("flush no pulse", 32'(update_valid), 32'd0);
        idle();
        chk("flush quiet", 32'(update_valid), 32'd0);

        // Reset mid-drain.
        do_reset();
        for (int i = 0; i < 4; i++) alloc(32'h700 + 32'(i * 8), 1'b1);
        for (int i = 0; i < 4; i++) res(3'(i), 1'b0);
        chk("mid drain active", 32'(update_valid), 32'd1);
        do_reset();
        chk("rst update_valid", 32'(update_valid), 32'd0);
        chk("rst update_pc", update_pc, 32'd0);
        chk("rst mispredict", 32'(update_mispredict), 32'd0);
        idle();
        chk("rst no pulse", 32'(update_valid), 32'd0);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
